smooth_pass_sequencer: RTL and testbench
========================================

# smooth_pass_sequencer

Sequences repeated Laplacian smoothing passes of the averager over the object mesh. Before the first pass it copies the object RAM into the result RAM, so both hold the same mesh when the averager starts. It then launches the averager and waits for it to finish. After every pass it copies the result RAM back into the object RAM, so the next pass, or the downstream stage, reads the smoothed mesh. Copies use port B of both dual-port RAMs; the averager keeps port A, so the two never contend.

## Interface
- ADDR_WIDTH, 9, word address width of the object and result RAMs
- PASS_W, 4, width of pass counter (max 15 passes)
- clk  input  1  clock; all block logic on posedge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle request; sampled in IDLE only
- pass_count  input  PASS_W  number of smoothing passes; sampled with start
- vertex_count  input  32  vertex count; sampled with start
- busy  output  1  high from accepted start until the done cycle inclusive
- done  output  1  one-cycle pulse at the end of a job
- err  output  1  valid with done; 1 = job rejected, no RAM or averager activity
- pass_idx  output  PASS_W  index of the current pass, 0-based
- avg_start  output  1  start to averager, held high exactly one clk cycle
- avg_busy  input  1  averager busy (driven on negedge)
- obj_b_en / res_b_en  output  1  port-B enables
- obj_b_a / res_b_a  output  ADDR_WIDTH  port-B addresses
- obj_b_we / res_b_we  output  4  port-B byte write enables (0000 or 1111)
- obj_b_di / res_b_di  output  32  port-B write data
- obj_b_do / res_b_do  input  32  port-B read data, one-cycle read latency

## Operation
- Reset value of every output is 0. The state returns to IDLE.
- Mesh layout: vertex v occupies words 3v+1..3v+3. Copy span is addresses 1..W, with W = 3·vertex_count.
- States: IDLE, PRIME, LAUNCH, WAIT_HI, WAIT_LO, WRITEBACK, DONE.
- IDLE:
  - start is accepted only when avg_busy = 0. Otherwise start is ignored and no error is raised.
  - On an accepted start, latch pass_count and vertex_count.
  - If vertex_count = 0, or vertex_count > (2^ADDR_WIDTH − 1)/3 (170 at the default width), go to DONE with err = 1.
  - Else if pass_count = 0, go to DONE with err = 0.
  - Else go to PRIME with pass_idx = 0.
- PRIME: copy engine, source OBJ, destination RES. Then go to LAUNCH.
- LAUNCH: avg_start = 1 for one cycle, then go to WAIT_HI.
- WAIT_HI: wait for avg_busy = 1, then go to WAIT_LO.
- WAIT_LO: wait for avg_busy = 0, then go to WRITEBACK.
- WRITEBACK: copy engine, source RES, destination OBJ. Then:
  - if pass_idx = pass_count − 1, go to DONE;
  - else increment pass_idx and go to LAUNCH.
- DONE: done = 1 and busy = 1 for one cycle; err is held. Then go to IDLE, where busy = 0 and err keeps its value until the next accepted start.
- Copy engine: a read counter rd_a runs 1..W.
  - Each cycle, issue a read of rd_a on the source port (en = 1).
  - On the following cycle, write the returned data to the same address on the destination port (we = 1111).
  - Throughput is one word per cycle.
- Port-B enables and write enables are 0 outside the copy states. The destination write in the final copy cycle is the only write without a read.
- The address arithmetic is 32-bit; W ≤ 510 is guaranteed by the range check.

## Timing
- Copy state occupancy is W+1 cycles:
  - reads at cycles 0..W−1 of the state;
  - writes at cycles 1..W; the write of address k occurs exactly one cycle after its read.
- LAUNCH lasts 1 cycle. avg_start goes high on the posedge entering LAUNCH and low on the next posedge, so the averager's negedge sees it exactly once.
- WAIT_HI has no timeout. The averager raises busy on the negedge within LAUNCH, so WAIT_HI normally lasts 1 cycle.
- Total job latency, from accepted start to the done cycle: 1 + (W+1) + P·(1 + T_avg + W + 1) cycles, where P = pass_count and T_avg = cycles of avg_busy high.
- Rejected job: done occurs 1 cycle after the accepted start.
- start during a job is ignored.
- rst_n asserted mid-job:
  - all outputs go to 0 immediately;
  - any copy in flight stops;
  - the averager is not reset, so a new start is refused until avg_busy = 0.

## Test plan
- vertex_count=2, pass_count=1, averager model present:
  - RES[1..6] equals OBJ[1..6] before avg_start;
  - PRIME lasts 7 cycles;
  - after WRITEBACK, OBJ[1..6] equals RES[1..6];
  - one done pulse with err=0.
- vertex_count=4, pass_count=3:
  - exactly 3 avg_start pulses, each 1 cycle wide;
  - pass_idx reads 0, 1, 2;
  - 4 copies of 13 cycles each;
  - the job cycle count matches the latency formula.
- vertex_count=171 -> done and err=1 one cycle after start; no port-B enable ever high; avg_start never high. vertex_count=0 -> same. vertex_count=5, pass_count=0 -> done with err=0 and no RAM activity.
- Hold avg_busy=1 externally and pulse start -> busy stays 0. Release avg_busy and pulse start -> job accepted. Pulse start again mid-job -> ignored; pass count unchanged.
- Drop rst_n during the 4th cycle of WRITEBACK -> all outputs are 0 in the same cycle. After release, a start with avg_busy=0 restarts from PRIME.
- Read-latency check (vertex_count=1):
  - res_b_we=1111 at address k exactly one cycle after obj_b_a=k;
  - res_b_di equals the obj_b_do from that read;
  - no write occurs to address 0 or 4.

Source files
------------

// File: rtl/smooth_pass_sequencer.sv
// Sequencer for repeated smoothing passes: primes RES from OBJ, runs the averager, copies RES back to OBJ.
// Latency: 1 + (W+1) + P*(1 + T_avg + W + 1) cycles from accepted start to done, W = 3*vertex_count.
// No backpressure: start is taken only in IDLE with the averager idle; copies stream one word per cycle.
module smooth_pass_sequencer #(
    parameter int ADDR_WIDTH = 9,
    parameter int PASS_W     = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [PASS_W-1:0]     pass_count,
    input  logic [31:0]           vertex_count,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [PASS_W-1:0]     pass_idx,
    output logic                  avg_start,
    input  logic                  avg_busy,
    output logic                  obj_b_en,
    output logic [ADDR_WIDTH-1:0] obj_b_a,
    output logic [3:0]            obj_b_we,
    output logic [31:0]           obj_b_di,
    input  logic [31:0]           obj_b_do,
    output logic                  res_b_en,
    output logic [ADDR_WIDTH-1:0] res_b_a,
    output logic [3:0]            res_b_we,
    output logic [31:0]           res_b_di,
    input  logic [31:0]           res_b_do
);

    typedef enum logic [2:0] {
        IDLE, PRIME, LAUNCH, WAIT_HI, WAIT_LO, WRITEBACK, DONE
    } state_t;

    // Largest vertex count whose last word 3v+3 still fits the address space.
    localparam logic [31:0] VMAX = 32'(((1 << ADDR_WIDTH) - 1) / 3);

    state_t              state_q, state_d;
    logic [PASS_W-1:0]   pass_q, pass_d;
    logic [PASS_W-1:0]   pidx_q, pidx_d;
    logic [31:0]         span_q, span_d;
    logic [31:0]         rd_a_q, rd_a_d;
    logic                err_q, err_d;

    logic                copy_act, rd_vld, wr_vld, copy_last;
    logic [ADDR_WIDTH-1:0] rd_addr, wr_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pass_q  <= '0;
            pidx_q  <= '0;
            span_q  <= '0;
            rd_a_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pass_q  <= pass_d;
            pidx_q  <= pidx_d;
            span_q  <= span_d;
            rd_a_q  <= rd_a_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pass_d  = pass_q;
        pidx_d  = pidx_q;
        span_d  = span_q;
        rd_a_d  = rd_a_q;
        err_d   = err_q;

        // rd_a leads the write address by one: read rd_a, write rd_a-1.
        copy_act  = (state_q == PRIME) || (state_q == WRITEBACK);
        rd_vld    = copy_act && (rd_a_q <= span_q);
        wr_vld    = copy_act && (rd_a_q >= 32'd2);
        copy_last = (rd_a_q == span_q + 32'd1);
        rd_addr   = ADDR_WIDTH'(rd_a_q);
        wr_addr   = ADDR_WIDTH'(rd_a_q - 32'd1);

        busy      = (state_q != IDLE);
        done      = (state_q == DONE);
        avg_start = (state_q == LAUNCH);
        err       = err_q;
        pass_idx  = pidx_q;

        obj_b_en = 1'b0;
        obj_b_a  = '0;
        obj_b_we = 4'h0;
        obj_b_di = '0;
        res_b_en = 1'b0;
        res_b_a  = '0;
        res_b_we = 4'h0;
        res_b_di = '0;

        case (state_q)
            IDLE: begin
                if (start && !avg_busy) begin
                    pass_d = pass_count;
                    span_d = vertex_count * 32'd3;
                    pidx_d = '0;
                    rd_a_d = 32'd1;
                    if (vertex_count == 32'd0 || vertex_count > VMAX) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        err_d   = 1'b0;
                        state_d = (pass_count == '0) ? DONE : PRIME;
                    end
                end
            end
            PRIME: begin
                obj_b_en = rd_vld;
                obj_b_a  = rd_vld ? rd_addr : '0;
                res_b_en = wr_vld;
                res_b_a  = wr_vld ? wr_addr : '0;
                res_b_we = wr_vld ? 4'hF : 4'h0;
                res_b_di = wr_vld ? obj_b_do : '0;
                rd_a_d   = rd_a_q + 32'd1;
                if (copy_last) begin
                    rd_a_d  = 32'd1;
                    state_d = LAUNCH;
                end
            end
            LAUNCH:  state_d = WAIT_HI;
            WAIT_HI: if (avg_busy)  state_d = WAIT_LO;
            WAIT_LO: if (!avg_busy) state_d = WRITEBACK;
            WRITEBACK: begin
                res_b_en = rd_vld;
                res_b_a  = rd_vld ? rd_addr : '0;
                obj_b_en = wr_vld;
                obj_b_a  = wr_vld ? wr_addr : '0;
                obj_b_we = wr_vld ? 4'hF : 4'h0;
                obj_b_di = wr_vld ? res_b_do : '0;
                rd_a_d   = rd_a_q + 32'd1;
                if (copy_last) begin
                    rd_a_d = 32'd1;
                    if (pidx_q == pass_q - PASS_W'(1)) begin
                        state_d = DONE;
                    end else begin
                        pidx_d  = pidx_q + PASS_W'(1);
                        state_d = LAUNCH;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_smooth_pass_sequencer.sv
// Bench for smooth_pass_sequencer: RAM and averager models plus a cycle-offset reference of the job schedule.
module tb_smooth_pass_sequencer;

    localparam int AW   = 9;
    localparam int VMAX = ((1 << AW) - 1) / 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [3:0]  pass_count;
    logic [31:0] vertex_count;
    logic        busy, done, err, avg_start, avg_busy;
    logic [3:0]  pass_idx;
    logic        obj_b_en, res_b_en;
    logic [8:0]  obj_b_a, res_b_a;
    logic [3:0]  obj_b_we, res_b_we;
    logic [31:0] obj_b_di, res_b_di, obj_b_do, res_b_do;

    smooth_pass_sequencer #(.ADDR_WIDTH(AW), .PASS_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .pass_count(pass_count),
        .vertex_count(vertex_count), .busy(busy), .done(done), .err(err),
        .pass_idx(pass_idx), .avg_start(avg_start), .avg_busy(avg_busy),
        .obj_b_en(obj_b_en), .obj_b_a(obj_b_a), .obj_b_we(obj_b_we),
        .obj_b_di(obj_b_di), .obj_b_do(obj_b_do),
        .res_b_en(res_b_en), .res_b_a(res_b_a), .res_b_we(res_b_we),
        .res_b_di(res_b_di), .res_b_do(res_b_do)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int n_avg = 0;

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (avg_start) n_avg <= n_avg + 1;

    // Job reference: everything below is set by the stimulus when a start is expected to be accepted.
    bit          job_on = 0;
    int          t0, jP, jT, jdone;
    int          jW = 0;
    bit          cur_err = 0, prev_err = 0;
    int          cur_pf = 0, prev_pidx = 0;
    logic [31:0] snap [512];

    // Dual-port RAM port B models; the averager adds 1000 to RES[1..W] when it is launched.
    logic [31:0] obj_mem [512];
    logic [31:0] res_mem [512];
    bit          mem_ready = 0;
    bit          bad_write = 0;

    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 512; i++) begin
                obj_mem[i] <= 32'(100 * i);
                res_mem[i] <= 32'd7;
            end
            mem_ready <= 1'b1;
        end else begin
            if (obj_b_en) begin
                obj_b_do <= obj_mem[obj_b_a];
                if (obj_b_we == 4'hF) obj_mem[obj_b_a] <= obj_b_di;
            end
            if (res_b_en) begin
                res_b_do <= res_mem[res_b_a];
                if (res_b_we == 4'hF) res_mem[res_b_a] <= res_b_di;
            end
            if ((obj_b_we != 4'h0 && (obj_b_a == 9'd0 || int'(obj_b_a) > jW)) ||
                (res_b_we != 4'h0 && (res_b_a == 9'd0 || int'(res_b_a) > jW)))
                bad_write <= 1'b1;
            if (avg_start)
                for (int i = 1; i <= jW && i < 512; i++) res_mem[i] <= res_mem[i] + 32'd1000;
        end
    end

    int avg_T = 3;
    int a_cnt = 0;
    bit ext_hold = 0;

    always @(negedge clk) begin
        if (avg_start) a_cnt = avg_T;
        else if (a_cnt > 0) a_cnt = a_cnt - 1;
        avg_busy <= ext_hold || (a_cnt > 0);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Per-cycle reference: the offset from the accepted start picks the phase arithmetically.
    always @(negedge clk) begin : cmp
        int off, r, q, c, x, e_pidx;
        bit prm, e_busy, e_done, e_avg, e_err;
        bit e_oen, e_ren, e_owe, e_rwe;
        int e_oa, e_ra;
        logic [31:0] e_odi, e_rdi;
        if (!rst_n) begin
            chk("rst busy", 32'(busy), 0);
            chk("rst done", 32'(done), 0);
            chk("rst err", 32'(err), 0);
            chk("rst avg_start", 32'(avg_start), 0);
            chk("rst pass_idx", 32'(pass_idx), 0);
            chk("rst obj_b_en", 32'(obj_b_en), 0);
            chk("rst res_b_en", 32'(res_b_en), 0);
            chk("rst obj_b_we", 32'(obj_b_we), 0);
            chk("rst res_b_we", 32'(res_b_we), 0);
        end else begin
            e_busy = 0; e_done = 0; e_avg = 0; e_err = prev_err; e_pidx = prev_pidx;
            e_oen = 0; e_ren = 0; e_owe = 0; e_rwe = 0;
            e_oa = 0; e_ra = 0; e_odi = 0; e_rdi = 0;
            c = -1; prm = 0;
            if (job_on) begin
                off = cyc - t0;
                x = jT + jW + 2;
                if (off >= 1) begin
                    e_err = cur_err;
                    e_pidx = 0;
                end
                if (off > jdone) begin
                    e_pidx = cur_pf;
                end else if (off >= 1) begin
                    e_busy = 1;
                    if (off == jdone) begin
                        e_done = 1;
                        e_pidx = cur_pf;
                    end else if (off <= jW + 1) begin
                        c = off - 1;
                        prm = 1;
                    end else begin
                        r = off - (jW + 2);
                        q = r % x;
                        e_pidx = r / x;
                        if (q == 0) e_avg = 1;
                        else if (q > jT) c = q - jT - 1;
                    end
                end
            end
            if (c >= 0) begin
                if (prm) begin
                    e_oen = (c < jW); e_oa = c + 1;
                    e_ren = (c >= 1); e_rwe = (c >= 1); e_ra = c; e_rdi = obj_mem[c];
                end else begin
                    e_ren = (c < jW); e_ra = c + 1;
                    e_oen = (c >= 1); e_owe = (c >= 1); e_oa = c; e_odi = res_mem[c];
                end
            end
            chk("busy", 32'(busy), 32'(e_busy));
            chk("done", 32'(done), 32'(e_done));
            chk("err", 32'(err), 32'(e_err));
            chk("avg_start", 32'(avg_start), 32'(e_avg));
            chk("pass_idx", 32'(pass_idx), 32'(e_pidx));
            chk("obj_b_en", 32'(obj_b_en), 32'(e_oen));
            chk("res_b_en", 32'(res_b_en), 32'(e_ren));
            chk("obj_b_we", 32'(obj_b_we), e_owe ? 32'hF : 32'h0);
            chk("res_b_we", 32'(res_b_we), e_rwe ? 32'hF : 32'h0);
            if (e_oen) chk("obj_b_a", 32'(obj_b_a), 32'(e_oa));
            if (e_ren) chk("res_b_a", 32'(res_b_a), 32'(e_ra));
            if (e_owe) chk("obj_b_di", obj_b_di, e_odi);
            if (e_rwe) chk("res_b_di", res_b_di, e_rdi);
        end
    end

    function automatic int done_off(input int v, input int p, input int t);
        int w;
        if (v == 0 || v > VMAX || p == 0) return 1;
        w = 3 * v;
        return w + 2 + p * (t + w + 2);
    endfunction

    task automatic launch(input int v, input int p, input bit track);
        @(posedge clk); #1;
        vertex_count = 32'(v);
        pass_count   = 4'(p);
        start        = 1'b1;
        if (track) begin
            if (job_on) begin
                prev_err  = cur_err;
                prev_pidx = cur_pf;
            end
            for (int i = 0; i < 512; i++) snap[i] = obj_mem[i];
            cur_err = (v == 0 || v > VMAX);
            jW      = cur_err ? 0 : 3 * v;
            jP      = p;
            jT      = avg_T;
            cur_pf  = (!cur_err && p > 0) ? p - 1 : 0;
            jdone   = done_off(v, p, avg_T);
            t0      = cyc;
            job_on  = 1;
        end
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string nm, input int exp_off, input bit exp_err);
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (done === 1'b1) break;
        end
        chk({nm, " done offset"}, 32'(cyc - t0), 32'(exp_off));
        chk({nm, " err"}, 32'(err), 32'(exp_err));
    endtask

    task automatic wait_avg(input string nm, input int exp_off);
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (avg_start === 1'b1) break;
        end
        chk({nm, " first avg_start offset"}, 32'(cyc - t0), 32'(exp_off));
    endtask

    task automatic check_mem(input string nm);
        logic [31:0] e;
        for (int i = 0; i <= jW + 1 && i < 512; i++) begin
            e = (i >= 1 && i <= jW) ? snap[i] + 32'(1000 * jP) : snap[i];
            chk({nm, " obj word"}, obj_mem[i], e);
            if (i >= 1 && i <= jW) chk({nm, " res word"}, res_mem[i], e);
        end
    endtask

    task automatic check_all_zero(input string nm);
        chk({nm, " busy"}, 32'(busy), 0);
        chk({nm, " err"}, 32'(err), 0);
        chk({nm, " pass_idx"}, 32'(pass_idx), 0);
        chk({nm, " avg_start"}, 32'(avg_start), 0);
        chk({nm, " obj_b_en"}, 32'(obj_b_en), 0);
        chk({nm, " res_b_en"}, 32'(res_b_en), 0);
        chk({nm, " res_b_we"}, 32'(res_b_we), 0);
        chk({nm, " obj_b_we"}, 32'(obj_b_we), 0);
    endtask

    int n_before;

    initial begin
        rst_n = 1'b1; start = 1'b0; pass_count = '0; vertex_count = '0;
        #2 rst_n = 1'b0;
        #2 check_all_zero("reset");
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // V=2, P=1: PRIME spans 7 cycles, RES matches OBJ at launch, done at offset 19.
        avg_T = 3;
        launch(2, 1, 1);
        wait_avg("jobA", 8);
        for (int i = 1; i <= 6; i++) chk("jobA res primed", res_mem[i], snap[i]);
        wait_done("jobA", 19, 0);
        check_mem("jobA");
        chk("jobA obj[3] literal", obj_mem[3], 32'd1300);
        chk("jobA obj[7] literal", obj_mem[7], 32'd700);

        // V=4, P=3: three launches, done at 14 + 3*17 = 65.
        n_before = n_avg;
        launch(4, 3, 1);
        wait_done("jobB", 65, 0);
        chk("jobB avg_start pulses", 32'(n_avg - n_before), 32'd3);
        check_mem("jobB");
        chk("jobB obj[12] literal", obj_mem[12], 32'd4200);
        chk("jobB obj[13] literal", obj_mem[13], 32'd1300);

        // Rejections and the zero-pass job finish one cycle after start.
        launch(171, 2, 1);
        wait_done("v171", 1, 1);
        launch(0, 2, 1);
        wait_done("v0", 1, 1);
        launch(5, 0, 1);
        wait_done("p0", 1, 0);
        repeat (2) @(posedge clk);

        // Largest legal mesh.
        launch(170, 1, 1);
        wait_done("v170", 1027, 0);
        check_mem("v170");

        // Averager already busy: start refused.
        ext_hold = 1;
        repeat (2) @(negedge clk);
        launch(2, 1, 0);
        repeat (4) @(negedge clk);
        chk("held start busy", 32'(busy), 0);
        ext_hold = 0;
        repeat (2) @(negedge clk);

        // V=1, P=2, T=2 with a stray mid-job start: done at 5 + 2*7 = 19.
        avg_T = 2;
        launch(1, 2, 1);
        repeat (4) @(posedge clk);
        launch(5, 7, 0);
        wait_done("jobV1", 19, 0);
        check_mem("jobV1");
        chk("no write outside span", 32'(bad_write), 0);

        // Reset in the 4th WRITEBACK cycle, then a fresh job.
        avg_T = 3;
        launch(2, 1, 1);
        for (int i = 0; i < 100 && cyc != t0 + 15; i++) begin
            @(posedge clk); #1;
        end
        chk("abort reached writeback", 32'(res_b_en), 1);
        #2 rst_n = 1'b0;
        job_on = 0; prev_err = 0; prev_pidx = 0; jW = 0;
        #1 check_all_zero("abort");
        @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        launch(2, 2, 1);
        wait_done("restart", 30, 0);
        check_mem("restart");
        chk("no write outside span end", 32'(bad_write), 0);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
